// File: rtl/elevator_pkg.sv
// Shared elevator constants and types.
// Used by the scheduler and the controller.
package elevator_pkg;
  localparam int   NUM_FLOORS = 16;
  localparam int   FLOOR_W    = 4;
  localparam logic DIR_UP     = 1'b1;
  localparam logic DIR_DOWN   = 1'b0;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } sched_state_e;
endpackage

// File: rtl/call_debounce.sv
// One call button: 2-flop sync, debounce
// counter and a registered rising-edge pulse.
module call_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  logic [1:0] sync_q, sync_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic [3:0] cnt_q, cnt_d;

  // count consecutive samples that disagree with the accepted level
  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == 4'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/floor_request_scheduler.sv
// Call capture plus SCAN target scheduler.
// Issues the next floor to the controller.
module floor_request_scheduler #(
  parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [3:0]            current_floor,
  input  logic                  door_open,
  output logic [3:0]            requested_floor,
  output logic                  req_strobe,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  sched_dir
);
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [NUM_FLOORS-1:0] clr_mask;

  sched_state_e state_q, state_d;
  floor_t       req_q, req_d;
  logic         strobe_q, strobe_d;
  logic         dir_q, dir_d;
  logic         live_q, live_d;

  floor_t up_tgt, dn_tgt, up_dist, dn_dist;
  logic   up_found, dn_found, take_up;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    call_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn_i (call_btn[g]),
      .rise_o(rise[g])
    );
  end

  // new presses set bits; door at a floor clears it, clear wins
  always_comb begin
    clr_mask = '0;
    clr_mask[current_floor] = door_open;
    pend_d = (pend_q | rise) & ~clr_mask;
  end

  // nearest pending floor at/above and at/below the car
  always_comb begin
    up_found = 1'b0;
    up_tgt   = '0;
    dn_found = 1'b0;
    dn_tgt   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pend_q[i] && i >= int'(current_floor)) begin
        up_found = 1'b1;
        up_tgt   = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend_q[i] && i <= int'(current_floor)) begin
        dn_found = 1'b1;
        dn_tgt   = FLOOR_W'(i);
      end
    end
    up_dist = up_tgt - current_floor;
    dn_dist = current_floor - dn_tgt;
    take_up = up_found && (!dn_found || up_dist <= dn_dist);
  end

  // SCAN next-state; live_q marks the held target as not yet served
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    strobe_d = 1'b0;
    dir_d    = dir_q;
    live_d   = live_q;
    if (door_open && current_floor == req_q)
      live_d = 1'b0;
    if (!door_open && !strobe_q) begin
      unique case (state_q)
        IDLE: begin
          if (up_found || dn_found) begin
            strobe_d = 1'b1;
            live_d   = 1'b1;
            if (take_up) begin
              state_d = SWEEP_UP;
              dir_d   = DIR_UP;
              req_d   = up_tgt;
            end else begin
              state_d = SWEEP_DOWN;
              dir_d   = DIR_DOWN;
              req_d   = dn_tgt;
            end
          end
        end
        SWEEP_UP: begin
          if (up_found) begin
            if (up_tgt != req_q || !live_q) begin
              req_d    = up_tgt;
              strobe_d = 1'b1;
              live_d   = 1'b1;
            end
          end else if (dn_found) begin
            state_d = SWEEP_DOWN;
            dir_d   = DIR_DOWN;
          end else begin
            state_d = IDLE;
          end
        end
        SWEEP_DOWN: begin
          if (dn_found) begin
            if (dn_tgt != req_q || !live_q) begin
              req_d    = dn_tgt;
              strobe_d = 1'b1;
              live_d   = 1'b1;
            end
          end else if (up_found) begin
            state_d = SWEEP_UP;
            dir_d   = DIR_UP;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // scheduler and bitmap registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      state_q  <= IDLE;
      req_q    <= '0;
      strobe_q <= 1'b0;
      dir_q    <= DIR_UP;
      live_q   <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      state_q  <= state_d;
      req_q    <= req_d;
      strobe_q <= strobe_d;
      dir_q    <= dir_d;
      live_q   <= live_d;
    end
  end

  assign pending         = pend_q;
  assign requested_floor = req_q;
  assign req_strobe      = strobe_q;
  assign sched_dir       = dir_q;
endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: directed
// scenarios plus random calls against a model.
module tb_floor_request_scheduler;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] call_btn = '0;
  logic [3:0]  current_floor = '0;
  logic        door_open = 1'b0;
  logic [3:0]  requested_floor;
  logic        req_strobe;
  logic [15:0] pending;
  logic        sched_dir;

  int n_chk  = 0;
  int n_pass = 0;

  floor_request_scheduler #(
    .NUM_FLOORS(16),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .call_btn(call_btn),
    .current_floor(current_floor),
    .door_open(door_open),
    .requested_floor(requested_floor),
    .req_strobe(req_strobe),
    .pending(pending),
    .sched_dir(sched_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model: button sample history and
  // the SCAN rules expressed on floor numbers
  logic [15:0] m_s1, m_s2, m_deb, m_rise, m_pend;
  logic [31:0] m_hist [16];
  int          m_req, m_mode;
  logic        m_strobe, m_dir, m_served;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    m_rise = '0; m_pend = '0;
    for (int n = 0; n < 16; n++) m_hist[n] = '0;
    m_req = 0; m_mode = 0;
    m_strobe = 1'b0; m_dir = 1'b1;
    m_served = 1'b1;
  endtask

  task automatic model_step(input logic [15:0] b,
                            input int cf,
                            input logic door);
    logic [15:0] old_pend, old_rise, new_rise;
    logic [31:0] win;
    logic        old_strobe;
    int          up, dn, issue;
    win = (32'd1 << D) - 32'd1;
    old_pend = m_pend;
    old_rise = m_rise;
    old_strobe = m_strobe;
    new_rise = '0;
    for (int n = 0; n < 16; n++) begin
      m_hist[n] = {m_hist[n][30:0], m_s2[n]};
      if (!m_deb[n] && (m_hist[n] & win) == win) begin
        m_deb[n] = 1'b1;
        new_rise[n] = 1'b1;
      end else if (m_deb[n] && (m_hist[n] & win) == 0) begin
        m_deb[n] = 1'b0;
      end
    end
    m_s2 = m_s1;
    m_s1 = b;
    m_rise = new_rise;
    m_pend = old_pend | old_rise;
    if (door) m_pend[cf] = 1'b0;
    up = -1;
    for (int f = cf; f < 16; f++)
      if (up < 0 && old_pend[f]) up = f;
    dn = -1;
    for (int f = cf; f >= 0; f--)
      if (dn < 0 && old_pend[f]) dn = f;
    issue = -1;
    if (door && cf == m_req) m_served = 1'b1;
    if (!door && !old_strobe) begin
      if (m_mode == 0) begin
        if (up >= 0 && (dn < 0 || up - cf <= cf - dn)) begin
          issue = up; m_mode = 1; m_dir = 1'b1;
        end else if (dn >= 0) begin
          issue = dn; m_mode = -1; m_dir = 1'b0;
        end
      end else if (m_mode == 1) begin
        if (up >= 0) begin
          if (up != m_req || m_served) issue = up;
        end else if (dn >= 0) begin
          m_mode = -1; m_dir = 1'b0;
        end else m_mode = 0;
      end else begin
        if (dn >= 0) begin
          if (dn != m_req || m_served) issue = dn;
        end else if (up >= 0) begin
          m_mode = 1; m_dir = 1'b1;
        end else m_mode = 0;
      end
    end
    m_strobe = (issue >= 0);
    if (issue >= 0) begin
      m_req = issue;
      m_served = 1'b0;
    end
  endtask

  // one clock: drive at negedge, step model at
  // posedge, compare at the following negedge
  task automatic cyc(input logic [15:0] b,
                     input logic [3:0] f,
                     input logic d);
    call_btn = b;
    current_floor = f;
    door_open = d;
    @(posedge clk);
    model_step(b, int'(f), d);
    @(negedge clk);
    chk("pending", 32'(pending), 32'(m_pend));
    chk("req_floor", 32'(requested_floor), 32'(m_req));
    chk("strobe", 32'(req_strobe), 32'(m_strobe));
    chk("dir", 32'(sched_dir), 32'(m_dir));
  endtask

  // reset asserted between edges, checked before any edge
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_req", 32'(requested_floor), 32'h0);
    chk("rst_strobe", 32'(req_strobe), 32'h0);
    chk("rst_dir", 32'(sched_dir), 32'h1);
    model_reset();
    call_btn = '0;
    door_open = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rb;
    logic [3:0]  rf;
    logic        rd;
    int          k, nstb;

    model_reset();
    repeat (2) @(negedge clk);

    // single call from floor 0
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      cyc(16'h0020, 4'd0, 1'b0);
      if (c == 6) chk("t1_pend_c6", 32'(pending), 32'h0);
      if (c == 7) chk("t1_pend_c7", 32'(pending), 32'h20);
      if (c == 7) chk("t1_nostb_c7", 32'(req_strobe), 32'h0);
      if (c == 8) begin
        chk("t1_req", 32'(requested_floor), 32'd5);
        chk("t1_stb", 32'(req_strobe), 32'h1);
        chk("t1_dir", 32'(sched_dir), 32'h1);
      end
      if (c == 9) chk("t1_stb_c9", 32'(req_strobe), 32'h0);
    end

    // 3-cycle glitch must be rejected
    do_reset();
    nstb = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc((c <= 3) ? 16'h0008 : 16'h0, 4'd0, 1'b0);
      nstb += int'(req_strobe);
    end
    chk("t2_pend", 32'(pending), 32'h0);
    chk("t2_nstb", 32'(nstb), 32'd0);

    // nearer call wins, then reverse after serving
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      cyc(16'h0204, 4'd6, 1'b0);
      if (c == 8) begin
        chk("t3_req9", 32'(requested_floor), 32'd9);
        chk("t3_dir_up", 32'(sched_dir), 32'h1);
      end
    end
    cyc(16'h0, 4'd9, 1'b1);
    chk("t3_clr9", 32'(pending), 32'h0004);
    for (int c = 1; c <= 4; c++) cyc(16'h0, 4'd9, 1'b0);
    chk("t3_req2", 32'(requested_floor), 32'd2);
    chk("t3_dir_dn", 32'(sched_dir), 32'h0);

    // equal distance goes up
    do_reset();
    for (int c = 1; c <= 9; c++) cyc(16'h0044, 4'd4, 1'b0);
    chk("t4_req6", 32'(requested_floor), 32'd6);
    chk("t4_dir", 32'(sched_dir), 32'h1);

    // serve 3, press 3 again from floor 10
    do_reset();
    for (int c = 1; c <= 9; c++) cyc(16'h0008, 4'd0, 1'b0);
    chk("t5_req3", 32'(requested_floor), 32'd3);
    cyc(16'h0, 4'd3, 1'b1);
    for (int c = 1; c <= 10; c++) cyc(16'h0, 4'd10, 1'b0);
    nstb = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc(16'h0008, 4'd10, 1'b0);
      nstb += int'(req_strobe);
    end
    chk("t5_nstb", 32'(nstb), 32'd1);
    chk("t5_req_hold", 32'(requested_floor), 32'd3);

    // reset while sweeping with 0x8001 pending
    do_reset();
    for (int c = 1; c <= 9; c++) cyc(16'h8001, 4'd7, 1'b0);
    chk("t6_pend", 32'(pending), 32'h8001);
    do_reset();

    // press at the open-door floor: clear wins
    for (int c = 1; c <= 12; c++) cyc(16'h0080, 4'd7, 1'b1);
    chk("t7_pend", 32'(pending), 32'h0);
    chk("t7_stb", 32'(req_strobe), 32'h0);

    // random traffic against the model
    do_reset();
    rb = '0;
    rf = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        rb = '0;
      end
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, 15));
        rb[k] = ~rb[k];
      end
      if ($urandom_range(0, 7) == 0)
        rf = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0)
        rf = 4'(m_req);
      rd = ($urandom_range(0, 6) == 0);
      cyc(rb, rf, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
